// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: execute->writeback memory stage driving a req/gnt/rvalid data port.
// Build option MISALIGN_TRAP_EN: misaligned H/W/D accesses fault instead of issuing a request.
module lsu_mem_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       alu_data,
   input  logic [XLEN-1:0]       store_data,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [INST_WIDTH-1:0] ir,
   output logic                  out_valid,
   output logic [XLEN-1:0]       alu_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic [INST_WIDTH-1:0] ir_out,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [XLEN-1:0]       mem_addr,
   output logic [XLEN/8-1:0]     mem_be,
   output logic [XLEN-1:0]       mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  misalign
);

   localparam int BW = XLEN / 8;
   localparam int OW = $clog2(BW);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
   state_t state, next_state;

   logic                  accept, is_load, is_store, is_mem, fault;
   logic [1:0]            size;
   logic [OW-1:0]         off, eff_off;
   logic [BW-1:0]         be;
   logic [XLEN-1:0]       wdata;

   logic                  store_q, unsigned_q;
   logic [1:0]            size_q;
   logic [OW-1:0]         off_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [INST_WIDTH-1:0] ir_q;
   logic [XLEN-1:0]       addr_q;

   logic [XLEN-1:0]       shifted, data_mask, load_data;
   logic                  sign;

   // Address bits below the access size (size 0..3 -> 0,1,3,7).
   function automatic logic [OW-1:0] low_mask(input logic [1:0] s);
      logic [OW-1:0] m;
      for (int i = 0; i < OW; i++) m[i] = (i < int'(s));
      return m;
   endfunction

   function automatic logic [BW-1:0] byte_mask(input logic [1:0] s);
      logic [BW-1:0] m;
      for (int i = 0; i < BW; i++) m[i] = (i < (1 << int'(s)));
      return m;
   endfunction

   function automatic logic [XLEN-1:0] bit_mask(input logic [1:0] s);
      logic [XLEN-1:0] m;
      for (int i = 0; i < XLEN; i++) m[i] = (i < (8 << int'(s)));
      return m;
   endfunction

   assign accept = in_valid & in_ready;

   always_comb begin
      is_load  = (ir[6:0] == 7'b0000011);
      is_store = (ir[6:0] == 7'b0100011);
      is_mem   = is_load | is_store;
      size     = ir[13:12];
      if (XLEN == 32 && size == 2'd3) size = 2'd2;
      off      = alu_data[OW-1:0];
      eff_off  = off & ~low_mask(size);
      be       = byte_mask(size) << eff_off;
      case (size)
         2'd0:    wdata = {BW{store_data[7:0]}};
         2'd1:    wdata = {(BW/2){store_data[15:0]}};
         2'd2:    wdata = {(BW/4){store_data[31:0]}};
         default: wdata = store_data;
      endcase
`ifdef MISALIGN_TRAP_EN
      fault = is_mem & (|(off & low_mask(size)));
`else
      fault = 1'b0;
`endif
   end

   // Lane select, then mask to size; the top bit of the mask marks the sign bit.
   always_comb begin
      shifted   = mem_rdata >> {off_q, 3'b000};
      data_mask = bit_mask(size_q);
      sign      = ~unsigned_q & (|(shifted & (data_mask ^ (data_mask >> 1))));
      load_data = (shifted & data_mask) | (sign ? ~data_mask : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept && is_mem && !fault) next_state = REQ;
         REQ:     if (mem_gnt) next_state = store_q ? IDLE : RESP;
         RESP:    if (mem_rvalid) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      mem_req  = (state == REQ);
      mem_we   = (state == REQ) & store_q;
   end

   // Completed stores report their effective address on alu_out with rd_out=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         misalign   <= 1'b0;
         alu_out    <= '0;
         rd_out     <= '0;
         ir_out     <= '0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         store_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         ir_q       <= '0;
         addr_q     <= '0;
      end else begin
         out_valid <= 1'b0;
         misalign  <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               store_q    <= is_store;
               unsigned_q <= ir[14];
               size_q     <= size;
               off_q      <= eff_off;
               rd_q       <= rd;
               ir_q       <= ir;
               addr_q     <= alu_data;
               if (is_mem && !fault) begin
                  mem_addr  <= {alu_data[XLEN-1:OW], {OW{1'b0}}};
                  mem_be    <= be;
                  mem_wdata <= is_store ? wdata : '0;
               end else begin
                  out_valid <= 1'b1;
                  misalign  <= fault;
                  alu_out   <= alu_data;
                  rd_out    <= fault ? '0 : rd;
                  ir_out    <= ir;
               end
            end
            REQ: if (mem_gnt && store_q) begin
               out_valid <= 1'b1;
               alu_out   <= addr_q;
               rd_out    <= '0;
               ir_out    <= ir_q;
            end
            RESP: if (mem_rvalid) begin
               out_valid <= 1'b1;
               alu_out   <= load_data;
               rd_out    <= rd_q;
               ir_out    <= ir_q;
            end
            default: ;
         endcase
      end
   end

endmodule
